// File: rtl/bram_bus_pkg.sv
// Shared definitions for the trig/done BRAM bus: widths, controller state
// encoding and the row-to-address helper used by the line-search and filter engines.
package bram_bus_pkg;

   localparam int ADDR_W_DEF    = 13;
   localparam int DATA_W_DEF    = 32;
   localparam int WORDS_PER_ROW = 16;
   localparam int WORD_BITS     = $clog2(WORDS_PER_ROW);
   localparam int ROW_W         = ADDR_W_DEF - WORD_BITS;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_ISSUE,
      ST_RD_ISSUE,
      ST_RD_WAIT,
      ST_DONE
   } state_t;

   // Address of word 0 of a row (row * WORDS_PER_ROW).
   function automatic logic [ADDR_W_DEF-1:0] row_to_addr(input logic [ROW_W-1:0] row);
      return {row, {WORD_BITS{1'b0}}};
   endfunction

endpackage

// File: rtl/bram_rd_lat_pipe.sv
// RD_LAT-deep valid shift register: asserts valid in the cycle the BRAM
// primitive presents read data for a read issued RD_LAT cycles earlier.
module bram_rd_lat_pipe #(
   parameter int RD_LAT = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic issue,
   output logic valid
);

   logic [RD_LAT-1:0] shift;

   // NOTE: sequential state uses non-blocking assignments so every stage
   // samples the previous stage's value from before the clock edge.
   if (RD_LAT == 1) begin : g_one
      always_ff @(posedge clk) begin
         if (!rstn) shift <= '0;
         else       shift <= issue;
      end
   end else begin : g_many
      always_ff @(posedge clk) begin
         if (!rstn) shift <= '0;
         else       shift <= {shift[RD_LAT-2:0], issue};
      end
   end

   assign valid = shift[RD_LAT-1];

endmodule

// File: rtl/bram_rdwr_ctrl.sv
// Arbitrates one trig/done read channel and one write channel onto a
// single-port BRAM, returning done pulses and captured read data.
module bram_rdwr_ctrl
   import bram_bus_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int RD_LAT = 2
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic [ADDR_W-1:0] i_rd_addr,
   input  logic              i_rd_trig,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_rd_done,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_wr_trig,
   output logic              o_wr_done,
   output logic              o_bram_en,
   output logic              o_bram_we,
   output logic [ADDR_W-1:0] o_bram_addr,
   output logic [DATA_W-1:0] o_bram_din,
   input  logic [DATA_W-1:0] i_bram_dout,
   output logic              o_busy
);

   state_t state;
   logic   rd_arm;
   logic   wr_arm;
   logic   prio_rd;
   logic   rd_elig;
   logic   wr_elig;
   logic   grant_wr;
   logic   grant_rd;
   logic   rd_issue;
   logic   lat_valid;

   assign rd_elig  = i_rd_trig & rd_arm;
   assign wr_elig  = i_wr_trig & wr_arm;
   // The pointer only moves on contested grants, so contention alternates.
   assign grant_wr = wr_elig & (~rd_elig | ~prio_rd);
   assign grant_rd = rd_elig & (~wr_elig |  prio_rd);
   assign rd_issue = o_bram_en & ~o_bram_we;

   bram_rd_lat_pipe #(.RD_LAT(RD_LAT)) u_rd_lat_pipe (
      .clk   (i_clk),
      .rstn  (i_rstn),
      .issue (rd_issue),
      .valid (lat_valid)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state       <= ST_IDLE;
         rd_arm      <= 1'b1;
         wr_arm      <= 1'b1;
         prio_rd     <= 1'b0;
         o_rd_data   <= '0;
         o_rd_done   <= 1'b0;
         o_wr_done   <= 1'b0;
         o_bram_en   <= 1'b0;
         o_bram_we   <= 1'b0;
         o_bram_addr <= '0;
         o_bram_din  <= '0;
         o_busy      <= 1'b0;
      end else begin
         o_rd_done <= 1'b0;
         o_wr_done <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (grant_wr) begin
                  state       <= ST_WR_ISSUE;
                  o_bram_en   <= 1'b1;
                  o_bram_we   <= 1'b1;
                  o_bram_addr <= i_wr_addr;
                  o_bram_din  <= i_wr_data;
                  o_busy      <= 1'b1;
                  if (rd_elig) prio_rd <= 1'b1;
               end else if (grant_rd) begin
                  state       <= ST_RD_ISSUE;
                  o_bram_en   <= 1'b1;
                  o_bram_we   <= 1'b0;
                  o_bram_addr <= i_rd_addr;
                  o_busy      <= 1'b1;
                  if (wr_elig) prio_rd <= 1'b0;
               end
            end
            ST_WR_ISSUE: begin
               state     <= ST_DONE;
               o_bram_en <= 1'b0;
               o_bram_we <= 1'b0;
               o_wr_done <= 1'b1;
               wr_arm    <= 1'b0;
            end
            ST_RD_ISSUE: begin
               state     <= ST_RD_WAIT;
               o_bram_en <= 1'b0;
            end
            ST_RD_WAIT: begin
               if (lat_valid) begin
                  state     <= ST_DONE;
                  o_rd_data <= i_bram_dout;
                  o_rd_done <= 1'b1;
                  rd_arm    <= 1'b0;
               end
            end
            ST_DONE: begin
               state  <= ST_IDLE;
               o_busy <= 1'b0;
            end
            default: begin
               state     <= ST_IDLE;
               o_bram_en <= 1'b0;
               o_bram_we <= 1'b0;
               o_busy    <= 1'b0;
            end
         endcase

         // NOTE: placed after the case so a low trig re-arms even on the
         // done edge; the last non-blocking assignment to a flag wins.
         if (!i_rd_trig) rd_arm <= 1'b1;
         if (!i_wr_trig) wr_arm <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bram_rdwr_ctrl.sv
// Scoreboard bench: three controller lanes (RD_LAT = 1, 2, 3), each with its own
// BRAM model, run the same directed sequence; a monitor checks every done pulse.
module tb_bram_rdwr_ctrl;
   import bram_bus_pkg::*;

   localparam int AW    = ADDR_W_DEF;
   localparam int DW    = DATA_W_DEF;
   localparam int N_LAT = 3;

   typedef struct {
      bit          is_rd;
      logic [31:0] data;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   bit fin [N_LAT];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < N_LAT; g++) begin : g_lat
      localparam int LAT = g + 1;

      logic          rstn;
      logic [AW-1:0] rd_addr;
      logic          rd_trig;
      logic [DW-1:0] rd_data;
      logic          rd_done;
      logic [AW-1:0] wr_addr;
      logic [DW-1:0] wr_data;
      logic          wr_trig;
      logic          wr_done;
      logic          bram_en;
      logic          bram_we;
      logic [AW-1:0] bram_addr;
      logic [DW-1:0] bram_din;
      logic [DW-1:0] bram_dout;
      logic          busy;

      logic [DW-1:0] mem  [2**AW];
      logic [DW-1:0] pipe [LAT];
      exp_t          exp_q[$];
      exp_t          mon_e;
      int            en_cnt = 0;

      bram_rdwr_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
         .i_clk       (clk),
         .i_rstn      (rstn),
         .i_rd_addr   (rd_addr),
         .i_rd_trig   (rd_trig),
         .o_rd_data   (rd_data),
         .o_rd_done   (rd_done),
         .i_wr_addr   (wr_addr),
         .i_wr_data   (wr_data),
         .i_wr_trig   (wr_trig),
         .o_wr_done   (wr_done),
         .o_bram_en   (bram_en),
         .o_bram_we   (bram_we),
         .o_bram_addr (bram_addr),
         .o_bram_din  (bram_din),
         .i_bram_dout (bram_dout),
         .o_busy      (busy)
      );

      // Single-port BRAM with LAT-cycle read latency; garbage when not reading
      // so that a mistimed capture is visible.
      always @(posedge clk) begin
         if (bram_en && bram_we) mem[bram_addr] <= bram_din;
         pipe[0] <= (bram_en && !bram_we) ? mem[bram_addr] : 32'h0BAD_F00D;
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
      assign bram_dout = pipe[LAT-1];

      function automatic string nm(input string s);
         return $sformatf("L%0d_%s", LAT, s);
      endfunction

      always @(negedge clk) begin
         if (bram_en) en_cnt++;
         if (rd_done || wr_done) begin
            check(nm("done_exclusive"), 64'(rd_done & wr_done), 64'd0);
            check(nm("done_expected"), 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
               mon_e = exp_q.pop_front();
               check(nm(mon_e.is_rd ? "rd_kind" : "wr_kind"), 64'(rd_done), 64'(mon_e.is_rd));
               check(nm(mon_e.is_rd ? "rd_cycle" : "wr_cycle"), 64'(cyc), 64'(mon_e.due));
               if (mon_e.is_rd) check(nm("rd_data"), 64'(rd_data), 64'(mon_e.data));
            end
         end
      end

      task automatic tick();
         @(posedge clk);
         #1;
      endtask

      task automatic wait_done(input bit is_rd, input int hold);
         int k;
         k = 0;
         while (((is_rd ? rd_done : wr_done) == 1'b0) && k < 40) begin
            tick();
            k++;
         end
         check(nm(is_rd ? "rd_done_seen" : "wr_done_seen"), 64'(k < 40), 64'd1);
         repeat (hold) tick();
         if (is_rd) rd_trig = 1'b0;
         else       wr_trig = 1'b0;
         tick();
      endtask

      task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
         wr_addr = a;
         wr_data = d;
         wr_trig = 1'b1;
         exp_q.push_back('{is_rd: 1'b0, data: 32'h0, due: cyc + 2});
         wait_done(1'b0, hold);
      endtask

      task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
         rd_addr = a;
         rd_trig = 1'b1;
         exp_q.push_back('{is_rd: 1'b1, data: d, due: cyc + LAT + 2});
         wait_done(1'b1, hold);
      endtask

      // Read and write raised together on the same address.
      task automatic pair(input bit rd_first, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW-1:0] rd_exp);
         int t0;
         t0 = cyc;
         wr_addr = a;
         wr_data = wd;
         rd_addr = a;
         wr_trig = 1'b1;
         rd_trig = 1'b1;
         if (rd_first) begin
            exp_q.push_back('{is_rd: 1'b1, data: rd_exp, due: t0 + LAT + 2});
            exp_q.push_back('{is_rd: 1'b0, data: 32'h0,  due: t0 + LAT + 5});
            wait_done(1'b1, 0);
            wait_done(1'b0, 0);
         end else begin
            exp_q.push_back('{is_rd: 1'b0, data: 32'h0,  due: t0 + 2});
            exp_q.push_back('{is_rd: 1'b1, data: rd_exp, due: t0 + LAT + 5});
            wait_done(1'b0, 0);
            wait_done(1'b1, 0);
         end
      endtask

      initial begin
         int e0;
         logic [AW-1:0] row_a;
         rstn    = 1'b0;
         rd_trig = 1'b0;
         wr_trig = 1'b0;
         rd_addr = '0;
         wr_addr = '0;
         wr_data = '0;
         repeat (3) tick();
         check(nm("rst_busy"), 64'(busy), 64'd0);
         check(nm("rst_ctrl"), 64'({bram_en, bram_we, rd_done, wr_done}), 64'd0);
         check(nm("rst_rd_data"), 64'(rd_data), 64'd0);
         rstn = 1'b1;
         tick();

         // Contention right after reset: write first, then read first.
         pair(1'b0, 13'd100, 32'h1111_1111, 32'h1111_1111);
         pair(1'b1, 13'd100, 32'h2222_2222, 32'h1111_1111);
         do_read(13'd100, 32'h2222_2222, 0);

         row_a = row_to_addr(9'd20);
         do_write(row_a, 32'hDEAD_BEEF, 0);
         do_read(row_a, 32'hDEAD_BEEF, 0);

         // Trig held one cycle past done must not retrigger.
         e0 = en_cnt;
         do_read(row_a, 32'hDEAD_BEEF, 1);
         repeat (LAT + 4) tick();
         check(nm("hold_en_cycles"), 64'(en_cnt - e0), 64'd1);
         e0 = en_cnt;
         do_write(13'd200, 32'h0000_5A5A, 1);
         repeat (4) tick();
         check(nm("hold_wr_en_cycles"), 64'(en_cnt - e0), 64'd1);
         do_read(13'd200, 32'h0000_5A5A, 0);

         // Address extremes.
         do_write(13'd0,    32'h0000_0001, 0);
         do_write(13'd8191, 32'h8000_0000, 0);
         do_read(13'd0,    32'h0000_0001, 0);
         do_read(13'd8191, 32'h8000_0000, 0);

         // Preload row 20 and read it back word by word.
         for (int i = 0; i < WORDS_PER_ROW; i++)
            do_write(row_a + AW'(i), 32'hA5A5_0000 + 32'(i), 0);
         for (int i = 0; i < WORDS_PER_ROW; i++)
            do_read(row_a + AW'(i), 32'hA5A5_0000 + 32'(i), 0);

         // Reset while a read is waiting on the BRAM.
         rd_addr = row_a;
         rd_trig = 1'b1;
         tick();
         check(nm("rd_issue_ctrl"), 64'({busy, bram_en, bram_we}), 64'b110);
         check(nm("rd_issue_addr"), 64'(bram_addr), 64'(row_a));
         tick();
         rstn = 1'b0;
         tick();
         check(nm("mid_rst_busy"), 64'(busy), 64'd0);
         check(nm("mid_rst_ctrl"), 64'({bram_en, bram_we, rd_done, wr_done}), 64'd0);
         check(nm("mid_rst_rd_data"), 64'(rd_data), 64'd0);
         check(nm("mid_rst_addr"), 64'(bram_addr), 64'd0);
         check(nm("mid_rst_din"), 64'(bram_din), 64'd0);
         rstn = 1'b1;
         exp_q.push_back('{is_rd: 1'b1, data: 32'hA5A5_0000, due: cyc + LAT + 2});
         wait_done(1'b1, 0);

         repeat (6) tick();
         check(nm("queue_drained"), 64'(exp_q.size()), 64'd0);
         fin[g] = 1'b1;
      end
   end

   initial begin
      int k;
      k = 0;
      while (!(fin[0] && fin[1] && fin[2]) && k < 20000) begin
         @(posedge clk);
         k++;
      end
      check("all_lanes_finished", 64'({fin[0], fin[1], fin[2]}), 64'b111);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bram_rdwr_ctrl.md
Name: bram_rdwr_ctrl

Overview:
Synthesizable responder for the trig/done BRAM read and write buses driven by the line-search and filter engines. It accepts one read channel and one write channel, arbitrates them onto a single-port block RAM (13b address, 32b word, 8192 words = 512 rows x 16 words), and returns done pulses and read data. It replaces the behavioural read and write BRAM models in the datapath.

Parameters:
ADDR_W, 13, word address width
DATA_W, 32, word width
RD_LAT, 2, BRAM primitive read latency in cycles from en to valid dout (legal 1..3)

Ports:
i_clk  in  1  system clock
i_rstn  in  1  reset; synchronous, active-low
i_rd_addr  in  ADDR_W  read address; held stable while i_rd_trig is high
i_rd_trig  in  1  read request (level)
o_rd_data  out  DATA_W  read data; valid when o_rd_done=1, then held
o_rd_done  out  1  one-cycle read-complete pulse
i_wr_addr  in  ADDR_W  write address; stable while i_wr_trig is high
i_wr_data  in  DATA_W  write data; stable while i_wr_trig is high
i_wr_trig  in  1  write request (level)
o_wr_done  out  1  one-cycle write-complete pulse
o_bram_en  out  1  BRAM enable
o_bram_we  out  1  BRAM write enable
o_bram_addr  out  ADDR_W  BRAM address
o_bram_din  out  DATA_W  BRAM write data
i_bram_dout  in  DATA_W  BRAM read data, RD_LAT after en
o_busy  out  1  FSM not in IDLE

Behaviour:
- Clock i_clk; reset i_rstn synchronous, active-low. Reset forces all outputs to 0, FSM to IDLE, both arm flags to 1, grant pointer to write-first, and drops any in-flight transaction without a done pulse.
- Arm rule: a channel is eligible when trig=1 and its arm flag=1. Issuing done clears the arm flag. The flag sets again on any cycle with trig=0. A trig held high after done, for example by an initiator that drops trig one cycle late, never retriggers.
- Arbitration, sampled in IDLE only:
  - Only one channel eligible: grant it.
  - Both eligible: grant the channel opposite to the last grant. The first grant after reset goes to write.
  - A request arriving while busy waits, and is evaluated on return to IDLE.
- FSM states: IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, DONE.
  - IDLE -> WR_ISSUE or RD_ISSUE on grant. Address and data are registered at the grant edge.
  - WR_ISSUE: en=1, we=1, addr/din driven for exactly one cycle -> DONE.
  - RD_ISSUE: en=1, we=0 for one cycle -> RD_WAIT.
  - RD_WAIT: counts RD_LAT-1 cycles, then captures i_bram_dout into o_rd_data -> DONE.
  - DONE: pulses o_wr_done or o_rd_done for 1 cycle -> IDLE.
- Latency from the edge where trig is sampled:
  - Write: done high 2 cycles later.
  - Read: done high RD_LAT+2 cycles later.
  - Throughput: one transaction per 3 (write) or RD_LAT+3 (read) cycles.
- Outside WR_ISSUE/RD_ISSUE, o_bram_en=o_bram_we=0. o_bram_addr/o_bram_din hold their last value.
- o_rd_data updates only on read capture and holds otherwise. o_rd_done and o_wr_done are never high in the same cycle.
- Addresses 0 and 2^ADDR_W-1 are both legal; there is no wrap or range check.
- A read and a write to the same address eligible together return old or new data per the grant pointer. Initiators requiring ordering must serialize.
- Deassertion of trig mid-transaction is ignored: the transaction completes and done still pulses.

Decomposition:
- Shared package bram_bus_pkg: ADDR_W/DATA_W defaults, the FSM state encoding, and the words-per-row constant 16 used by initiators for row to address (row*16) computation.
- One natural sub-module, bram_rd_lat_pipe: the RD_LAT-deep valid shift register that times dout capture. The arbiter and FSM stay in the top.

Test Plan:
- Write 32'hDEADBEEF to 320 (row 20, word 0), then read 320 -> o_wr_done exactly 2 cycles after trig. o_rd_data=32'hDEADBEEF with o_rd_done 4 cycles after trig (RD_LAT=2).
- Read and write trig rise on the same edge, after reset -> write is served first. Read done follows; if the address matches, it returns the new data. Repeat the pair: read is now served first.
- Initiator holds trig high one cycle past done -> exactly one done pulse, exactly one o_bram_en cycle. Trig low then high -> second transaction accepted.
- Addresses 0 and 8191 written with 32'h1 and 32'h8000_0000, read back -> values match, no aliasing.
- i_rstn=0 during RD_WAIT -> next edge: all outputs 0, no o_rd_done. After release, a still-high i_rd_trig is accepted as a fresh read.
- RD_LAT=1 and RD_LAT=3 builds, back-to-back 16-word row read (addr 320..335) -> each done arrives RD_LAT+2 cycles after trig, and data matches the preloaded row.
